// File: rtl/tc_serial_pkg.sv
// ============================================================================
// Module : tc_serial_pkg
// Brief  : Shared types and constants for the serial sample loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tc_serial_pkg;

    localparam int SAMPLE_W = 12;   // converter D input width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tc_serial_loader_sample_fifo.sv
// ============================================================================
// Module : sample_fifo
// Brief  : DEPTH x WIDTH synchronous FIFO with registered storage, head output
//          forced to zero when empty, and a drop strobe for pushes into a full
//          FIFO that are not relieved by a same-edge pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sample_fifo
    import tc_serial_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic w_empty, w_full, w_do_pop, w_do_push;

    assign w_empty   = (cnt_q == '0);
    assign w_full    = (cnt_q == CNT_W'(DEPTH));
    assign w_do_pop  = pop_i && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    assign empty_o = w_empty;
    assign drop_o  = push_i && w_full && !w_do_pop;
    assign head_o  = w_empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tc_serial_loader.sv
// ============================================================================
// Module : tc_serial_loader
// Brief  : MSB-first bit-serial deserialiser feeding a small FIFO that drives
//          the converter D input. Optional macro TC_SERIAL_PARITY_EN adds an
//          even-parity trailer bit and a sticky par_err output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tc_serial_loader
    import tc_serial_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             sdi_en,
    input  logic             sdi_frame,
    input  logic             d_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] D,
    output logic             d_valid,
    output logic             len_err,
    output logic             ovr_err
`ifdef TC_SERIAL_PARITY_EN
  , output logic             par_err
`endif
);

`ifdef TC_SERIAL_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int BCNT_W = $clog2(FRAME_BITS + 1);

    state_t            state_q, state_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              armed_q, armed_d;
    logic              len_err_q, len_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic              par_err_q, par_err_d;

    logic              push;
    logic [WIDTH-1:0]  push_word;
    logic              len_set, par_set;
    logic              w_empty, w_drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        armed_d   = armed_q;
        push      = 1'b0;
        push_word = '0;
        len_set   = 1'b0;
        par_set   = 1'b0;

        // Frames are only accepted after a frame-low sample since reset.
        if (sdi_en && !sdi_frame) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sdi_en && sdi_frame && armed_q) begin
                    shreg_d = {{(WIDTH-1){1'b0}}, sdi};
                    cnt_d   = BCNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sdi_en) begin
                    if (!sdi_frame) begin
                        len_set = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == BCNT_W'(FRAME_BITS - 1)) begin
`ifdef TC_SERIAL_PARITY_EN
                        push_word = shreg_q;
                        if ((^shreg_q) == sdi) begin
                            push = 1'b1;
                        end else begin
                            par_set = 1'b1;
                        end
`else
                        push_word = {shreg_q[WIDTH-2:0], sdi};
                        push      = 1'b1;
`endif
                        cnt_d   = '0;
                        state_d = TAIL;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], sdi};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (sdi_en) begin
                    if (sdi_frame) begin
                        len_set = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over a coincident clear.
        len_err_d = len_set | (len_err_q & ~err_clr);
        ovr_err_d = w_drop  | (ovr_err_q & ~err_clr);
        par_err_d = par_set | (par_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            armed_q   <= 1'b0;
            len_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            armed_q   <= armed_d;
            len_err_q <= len_err_d;
            ovr_err_q <= ovr_err_d;
            par_err_q <= par_err_d;
        end
    end

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (d_ready),
        .head_o  (D),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    assign d_valid = !w_empty;
    assign len_err = len_err_q;
    assign ovr_err = ovr_err_q;
`ifdef TC_SERIAL_PARITY_EN
    assign par_err = par_err_q;
`else
    logic w_unused;
    assign w_unused = par_err_d ^ par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tc_serial_loader.sv
// ============================================================================
// Module : tb_tc_serial_loader
// Brief  : Self-checking bench for tc_serial_loader; directed frames plus
//          randomized frames against a queue-based frame-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tc_serial_loader;

    localparam int W     = 12;
    localparam int DEPTH = 2;
`ifdef TC_SERIAL_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n, sdi, sdi_en, sdi_frame, d_ready, err_clr;
    logic [W-1:0] D;
    logic         d_valid, len_err, ovr_err;
`ifdef TC_SERIAL_PARITY_EN
    logic         par_err;
`endif

    tc_serial_loader #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdi       (sdi),
        .sdi_en    (sdi_en),
        .sdi_frame (sdi_frame),
        .d_ready   (d_ready),
        .err_clr   (err_clr),
        .D         (D),
        .d_valid   (d_valid),
        .len_err   (len_err),
        .ovr_err   (ovr_err)
`ifdef TC_SERIAL_PARITY_EN
      , .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference: list of accepted words plus sticky flags.
    int unsigned m_q[$];
    bit          m_len, m_ovr, m_par;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".D"},       32'(D),   (m_q.size() > 0) ? m_q[0] : 32'd0);
        check({tag, ".d_valid"}, 32'(d_valid), 32'(m_q.size() > 0));
        check({tag, ".len_err"}, 32'(len_err), 32'(m_len));
        check({tag, ".ovr_err"}, 32'(ovr_err), 32'(m_ovr));
`ifdef TC_SERIAL_PARITY_EN
        check({tag, ".par_err"}, 32'(par_err), 32'(m_par));
`endif
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b, input logic f);
        sdi = b; sdi_frame = f; sdi_en = 1'b1;
        @(posedge clk);
        #1;
        sdi_en = 1'b0;
    endtask

    function automatic logic [31:0] frame_of(input logic [W-1:0] data);
`ifdef TC_SERIAL_PARITY_EN
        return {19'd0, data, ^data};
`else
        return {20'd0, data};
`endif
    endfunction

    // Sends bits word[nbits-1:0] MSB first, then one frame-low sample.
    task automatic send_frame(input logic [31:0] word, input int nbits, input int gap,
                              input bit pop_last);
        bit            full_before, popped, ok;
        logic [31:0]   v;
        int unsigned   data;
        for (int i = 0; i < nbits; i++) begin
            idle(gap);
            if (pop_last && i == nbits - 1) d_ready = 1'b1;
            full_before = (m_q.size() == DEPTH);
            strobe(word[nbits-1-i], 1'b1);
            popped  = d_ready && (m_q.size() > 0);
            d_ready = 1'b0;
            if (popped) void'(m_q.pop_front());
            if (i == FB - 1) begin
                v = word >> (nbits - FB);
`ifdef TC_SERIAL_PARITY_EN
                data = (v >> 1) & ((1 << W) - 1);
                ok   = ((^data[W-1:0]) == v[0]);
`else
                data = v & ((1 << W) - 1);
                ok   = 1'b1;
`endif
                if (!ok)                      m_par = 1'b1;
                else if (full_before && !popped) m_ovr = 1'b1;
                else                          m_q.push_back(data);
                check("latency.d_valid", 32'(d_valid), 32'(m_q.size() > 0));
            end
            if (i >= FB) m_len = 1'b1;
        end
        idle(gap);
        strobe(1'b0, 1'b0);
        if (nbits < FB) m_len = 1'b1;
    endtask

    task automatic pop_one();
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        d_ready = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        check_state("pop");
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_len = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
    endtask

    initial begin
        int nb, gp;
        logic [31:0] w;
        rst_n = 1'b0; sdi = 1'b0; sdi_en = 1'b0; sdi_frame = 1'b0;
        d_ready = 1'b0; err_clr = 1'b0;
        m_len = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;
        idle(1);
        strobe(1'b0, 1'b0);

        // Single word, bit strobe every third cycle.
        send_frame(frame_of(12'h805), FB, 2, 1'b0);
        check_state("load_805");
        pop_one();

        // Overrun on a third word into a full FIFO.
        send_frame(frame_of(12'h7FF), FB, 0, 1'b0);
        send_frame(frame_of(12'h800), FB, 0, 1'b0);
        send_frame(frame_of(12'h001), FB, 1, 1'b0);
        check_state("overrun");
        pop_one();
        pop_one();
        clear_err();
        check_state("ovr_clr");

        // Push into full FIFO with coincident pop.
        send_frame(frame_of(12'h111), FB, 0, 1'b0);
        send_frame(frame_of(12'h222), FB, 0, 1'b0);
        send_frame(frame_of(12'h123), FB, 1, 1'b1);
        check_state("push_pop_full");
        pop_one();
        pop_one();

        // Short frame, clear, then long frame.
        send_frame(32'h5A, 7, 1, 1'b0);
        check_state("short7");
        clear_err();
        check_state("len_clr");
        send_frame({frame_of(12'hABC), 2'b11}, FB + 2, 0, 1'b0);
        check_state("long");
        pop_one();
        clear_err();

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        m_q.delete(); m_len = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
        check_state("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 6; i < FB; i++) strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        check_state("after_reset_tail");
        send_frame(frame_of(12'hFFF), FB, 1, 1'b0);
        check_state("load_fff");
        pop_one();

`ifdef TC_SERIAL_PARITY_EN
        send_frame({19'd0, 12'h003, 1'b0}, FB, 0, 1'b0);
        check_state("par_good");
        pop_one();
        send_frame({19'd0, 12'h003, 1'b1}, FB, 0, 1'b0);
        check_state("par_bad");
        clear_err();
`endif

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)      nb = FB;
            else if (r < 9) nb = $urandom_range(1, FB - 1);
            else            nb = FB + $urandom_range(1, 3);
            w  = $urandom & ((32'd1 << nb) - 1);
            if (r < 5) w = (nb == FB) ? frame_of(w[W-1:0] ^ w[FB-1:FB-W]) : w;
            gp = $urandom_range(0, 2);
            send_frame(w, nb, gp, ($urandom_range(0, 3) == 0));
            check_state("rand_frame");
            repeat ($urandom_range(0, 2)) pop_one();
            if ($urandom_range(0, 4) == 0) begin
                clear_err();
                check_state("rand_clr");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
